pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Drives the stall/flush inputs of every pipeline register in the 5-stage MIPS core (F/D, D/E, E/M, M/W), including the D/E register's stallE/flushE.
- Resolves load-use and mfc0-use hazards, multi-cycle divide occupancy, I/D cache wait stalls, branch/jump mispredict squashes and exception flushes.
- Holds a divide-occupancy FSM and a pending-exception latch, so its outputs depend on history as well as on the current cycle's inputs.

Parameters:
- DIV_CYCLES, 33: cycles the divider occupies E, start cycle included. Legal range 2..63.
- CNT_W, 6: width of the divide counter. Must hold DIV_CYCLES-1.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- rsD  in  5  rs field of the instruction in D
- rtD  in  5  rt field of the instruction in D
- writeregE  in  5  destination register of the instruction in E
- regwriteE  in  1  instruction in E writes the register file
- memtoregE  in  1  instruction in E is a load
- cp0_to_regE  in  1  instruction in E is mfc0
- div_startE  in  1  a div/divu is in E this cycle
- mispredictE  in  1  branch or jump resolved wrong in E (includes jump_conflictE)
- excM  in  1  exception or eret committed in M
- i_stall  in  1  instruction cache busy
- d_stall  in  1  data cache busy
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold the named pipeline register
- flushF, flushD, flushE, flushM, flushW  out  1 each  clear the named pipeline register to zero
- div_busy  out  1  divider FSM is in RUN
- div_abort  out  1  divide cancelled by an exception

Behaviour:
- While resetn=0, the following take effect at the edge: state=IDLE, cnt=0, exc_pend=0. All stall outputs read 0 and all flush outputs read 1 during reset. div_busy=0, div_abort=0.
- Outputs are combinational from inputs and registered state, so there is zero-cycle latency from any input to the stall/flush outputs.
- mem_wait = i_stall | d_stall.
- use_haz = (memtoregE | cp0_to_regE) & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- div_hold = (state==IDLE & div_startE) | state==RUN.
- Divide FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when div_startE and no exception flush this cycle. Loads cnt=DIV_CYCLES-2.
  - RUN: cnt decrements each cycle unless mem_wait=1, in which case cnt is frozen. At cnt==0 (and mem_wait=0) go to DONE.
  - DONE -> IDLE unconditionally. In DONE, div_hold=0, so the divide result advances out of E.
  - While stallE=1 in DONE (mem_wait), stay in DONE.
- Priority, highest first. Only the highest active row drives outputs; unlisted outputs are 0.
  1. Exception, when excM & ~mem_wait, or exc_pend & ~mem_wait:
     - flushD=flushE=flushM=flushW=1 and flushF=1.
     - exc_pend cleared. If state!=IDLE, go to IDLE and pulse div_abort=1 for this cycle.
  2. mem_wait:
     - stallF=stallD=stallE=stallM=1 and flushW=1 (bubble into W; no double commit).
     - If excM=1 this cycle, set exc_pend=1. It stays set until applied.
  3. div_hold:
     - stallF=stallD=stallE=1 and flushM=1.
  4. mispredictE:
     - flushD=1. The delay slot already in D advances to E; the wrong-path fetch is squashed.
  5. use_haz:
     - stallF=stallD=1 and flushE=1 (bubble into E).
- mispredictE and div_hold together: the div itself cannot be the branch. If a div in E is the delay slot, mispredict was handled the cycle before. Row 3 wins.
- stallX and flushX are never both 1 for the same X.
- Reset mid-divide returns the FSM to IDLE. div_abort is not pulsed on reset.

Decomposition:
- Shared package (cpu_defs_pkg) holds:
  - the divide FSM state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2};
  - the DIV_CYCLES default, so the divider datapath and this block agree.
- One sub-module, div_occupancy_fsm, owns the state, cnt and div_busy/div_abort logic. It takes div_startE, mem_wait and exc_apply.
- The priority encoder stays in the top module.

Test Plan:
- Load-use: lw $5 in E (writeregE=5, memtoregE=1, regwriteE=1), rsD=5 -> stallF=stallD=1, flushE=1 for exactly one cycle. Same stimulus with writeregE=0 -> no stall.
- Divide: div_startE pulse, DIV_CYCLES=33 -> stallE=1 for 32 cycles starting at the start cycle, div_busy high 31 cycles, then DONE with stallE=0, then IDLE.
- Divide under d_stall: assert d_stall for 5 cycles mid-RUN -> total stallE duration 37 cycles, flushW=1 during those 5.
- Exception during mem_wait: excM=1 while i_stall=1 for 3 cycles -> no flush while stalled, exc_pend=1; flushD..W=1 on the first cycle i_stall=0, exc_pend returns to 0.
- Exception mid-divide: excM at RUN cnt=10 -> flush all, div_abort=1 for one cycle, state IDLE next cycle, div_busy=0.
- Reset: resetn=0 during RUN -> next cycle state IDLE; while low all flush=1 and all stall=0; after release no flush, no stall with idle inputs.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared core definitions: divider occupancy defaults and FSM state encoding
package cpu_defs_pkg;

  // Cycles a div/divu occupies E, start cycle included; the divider datapath uses the same value
  localparam int DIV_CYCLES_DEF = 33;
  localparam int DIV_CNT_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_occupancy_fsm.sv
// rtl/div_occupancy_fsm.sv - tracks how long a divide holds the E stage and cancels it on exceptions
module div_occupancy_fsm
  import cpu_defs_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = DIV_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       div_startE,
  input  logic       mem_wait,
  input  logic       exc_apply,
  output div_state_t state,
  output logic       div_busy,
  output logic       div_abort
);

  // cnt is loaded with DIV_CYCLES-2; the RUN cycle that sees cnt==1 is the last one, so RUN
  // lasts DIV_CYCLES-2 unfrozen cycles and start + RUN + DONE adds up to DIV_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Occupancy state machine; a cache wait freezes the count, an exception returns to IDLE
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_startE && !exc_apply) begin
            state <= RUN;
            cnt   <= CNT_LOAD;
          end
        end
        RUN: begin
          if (exc_apply) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!mem_wait) begin
            if (cnt <= CNT_ONE) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        DONE: begin
          // The result leaves E only once the pipe is not held by a cache wait
          if (exc_apply || !mem_wait) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Status flags; abort is a same-cycle pulse when an exception cancels an in-flight divide
  always_comb begin
    div_busy  = resetn && (state == RUN);
    div_abort = resetn && exc_apply && (state != IDLE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the F/D, D/E, E/M, M/W pipeline registers
module pipe_hazard_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = DIV_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic       cp0_to_regE,
  input  logic       div_startE,
  input  logic       mispredictE,
  input  logic       excM,
  input  logic       i_stall,
  input  logic       d_stall,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushF,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       div_busy,
  output logic       div_abort
);

  logic       mem_wait;
  logic       use_haz;
  logic       div_hold;
  logic       exc_apply;
  logic       exc_pend;
  div_state_t div_state;

  // Hazard terms derived from the current cycle and the registered divide/exception state
  always_comb begin
    mem_wait  = i_stall | d_stall;
    use_haz   = (memtoregE | cp0_to_regE) & regwriteE & (writeregE != 5'd0) &
                ((writeregE == rsD) | (writeregE == rtD));
    div_hold  = ((div_state == IDLE) & div_startE) | (div_state == RUN);
    exc_apply = (excM | exc_pend) & ~mem_wait;
  end

  // An exception seen while a cache holds the pipe is remembered until it can be applied
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_pend <= 1'b0;
    end else if (exc_apply) begin
      exc_pend <= 1'b0;
    end else if (mem_wait && excM) begin
      exc_pend <= 1'b1;
    end
  end

  div_occupancy_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_fsm (
    .clk        (clk),
    .resetn     (resetn),
    .div_startE (div_startE),
    .mem_wait   (mem_wait),
    .exc_apply  (exc_apply),
    .state      (div_state),
    .div_busy   (div_busy),
    .div_abort  (div_abort)
  );

  // Priority encoder: only the highest active condition drives stall/flush
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushF = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (!resetn) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (exc_apply) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (mem_wait) begin
      // Bubble into W so the instruction held in M does not commit twice
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (div_hold) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (mispredictE) begin
      // Delay slot in D proceeds; only the wrong-path fetch is squashed
      flushD = 1'b1;
    end else if (use_haz) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule
